// File: rtl/split_assign_loader.sv
`default_nettype none
// ============================================================================
// Module      : split_assign_loader
// Description : Assembles a narrow word stream into a flat assignment vector,
//               samples the checker verdict after a fixed latency and returns
//               it over a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module split_assign_loader #(
    parameter int WORD_W     = 16,
    parameter int TOTAL_BITS = 1500,
    parameter int CHECK_LAT  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [TOTAL_BITS-1:0] assign_vec,
    input  logic                  chk_x,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_sat,
    output logic                  r_err,
    output logic [CNT_W-1:0]      r_seq
);

    localparam int c_nwords = (TOTAL_BITS + WORD_W - 1) / WORD_W;
    localparam int c_idx_w  = (c_nwords > 1) ? $clog2(c_nwords) : 1;
    localparam int c_cnt_w  = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nwords - 1);
    localparam logic [c_cnt_w-1:0] c_lat      = c_cnt_w'(CHECK_LAT);

    localparam logic [1:0] c_st_load  = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    logic [1:0]            r_state;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_bad;
    logic [TOTAL_BITS-1:0] w_vec_next;
    logic                  w_accept;
    logic                  w_final;

    assign w_accept = s_valid & s_ready;
    assign w_final  = (r_idx == c_last_idx);

    // Candidate vector with the current word merged in; an early s_last also
    // clears every word slot above the one being written.
    for (genvar k = 0; k < c_nwords; k++) begin : g_word
        localparam int c_lo = k * WORD_W;
        localparam int c_w  = (TOTAL_BITS - c_lo < WORD_W) ? (TOTAL_BITS - c_lo) : WORD_W;

        assign w_vec_next[c_lo +: c_w] =
            (r_idx == c_idx_w'(k))               ? s_data[c_w-1:0] :
            (s_last && (r_idx < c_idx_w'(k)))    ? '0              :
                                                   assign_vec[c_lo +: c_w];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_load;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_bad      <= 1'b0;
            assign_vec <= '0;
            s_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
            r_seq      <= '0;
        end else begin
            case (r_state)
                c_st_load: begin
                    s_ready <= 1'b1;
                    if (w_accept) begin
                        assign_vec <= w_vec_next;
                        if (s_last) begin
                            r_bad   <= ~w_final;
                            r_cnt   <= '0;
                            s_ready <= 1'b0;
                            r_state <= c_st_wait;
                        end else if (w_final) begin
                            r_bad   <= 1'b1;
                            r_state <= c_st_drain;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_accept && s_last) begin
                        r_cnt   <= '0;
                        s_ready <= 1'b0;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt == c_lat) begin
                        r_sat   <= chk_x & ~r_bad;
                        r_err   <= r_bad;
                        r_valid <= 1'b1;
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_seq   <= r_seq + 1'b1;
                        r_idx   <= '0;
                        s_ready <= 1'b1;
                        r_state <= c_st_load;
                    end
                end
                default: r_state <= c_st_load;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_split_assign_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_assign_loader
// Description : Scoreboard bench for split_assign_loader with a behavioural
//               model of vector assembly, error marking and sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_assign_loader;

    localparam int WW = 16;
    localparam int TB = 40;
    localparam int CL = 2;
    localparam int CW = 2;
    localparam int NW = 3;

    typedef struct {
        logic [TB-1:0] vec;
        logic          sat;
        logic          err;
        logic [CW-1:0] seq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [WW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [TB-1:0] assign_vec;
    logic          chk_x;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          r_sat;
    logic          r_err;
    logic [CW-1:0] r_seq;

    logic          s_valid0 = 1'b0;
    logic          s_ready0;
    logic [WW-1:0] s_data0 = '0;
    logic          s_last0 = 1'b0;
    logic [TB-1:0] assign_vec0;
    logic          r_valid0;
    logic          r_sat0;
    logic          r_err0;
    logic [CW-1:0] r_seq0;

    int            checks = 0;
    int            passed = 0;
    int            cyc = 0;
    int            last_acc = -100;
    int            issued = 0;
    int            done = 0;
    logic          verdict = 1'b0;
    bit            hold_mode = 1'b0;
    logic [TB-1:0] mvec = '0;
    logic [CW-1:0] mseq = '0;
    logic [WW-1:0] wbuf [0:7];
    exp_t          q [$];

    split_assign_loader #(.WORD_W(WW), .TOTAL_BITS(TB), .CHECK_LAT(CL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .assign_vec(assign_vec), .chk_x(chk_x), .r_valid(r_valid),
        .r_ready(r_ready), .r_sat(r_sat), .r_err(r_err), .r_seq(r_seq)
    );

    split_assign_loader #(.WORD_W(WW), .TOTAL_BITS(TB), .CHECK_LAT(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
        .s_last(s_last0), .assign_vec(assign_vec0), .chk_x(1'b1), .r_valid(r_valid0),
        .r_ready(1'b1), .r_sat(r_sat0), .r_err(r_err0), .r_seq(r_seq0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Checker stand-in: the true verdict only on the cycle it should be sampled.
    assign chk_x = (cyc == last_acc + CL) ? verdict : ~verdict;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_stop(input string name);
        checks++;
        $display("FAIL %s: timed out", name);
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "bench aborted on timeout");
    endtask

    task automatic put_word(input logic [WW-1:0] d, input logic last);
        int t;
        int idle;
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = WW'($urandom);
            s_last  = 1'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_stop("word_accept");
        @(posedge clk);
        #1;
        if (last) last_acc = cyc;
    endtask

    task automatic run_asg(input int n, input logic v);
        exp_t        e;
        logic [47:0] tmp;
        int          t;
        verdict = v;
        tmp = {8'h00, mvec};
        for (int i = 0; i < n && i < NW; i++) tmp[i*WW +: WW] = wbuf[i];
        if (n < NW) tmp = tmp & ((48'h1 << (n * WW)) - 48'h1);
        mvec  = tmp[TB-1:0];
        e.vec = mvec;
        e.err = (n != NW);
        e.sat = v & ~e.err;
        e.seq = mseq;
        mseq  = mseq + 1'b1;
        q.push_back(e);
        issued++;
        for (int i = 0; i < n; i++) put_word(wbuf[i], (i == n - 1));
        s_valid = 1'b0;
        t = 0;
        while (done < issued && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_stop("result_wait");
    endtask

    // Monitor: pops the expectation when a result first appears, then checks
    // that it stays put while the consumer stalls.
    initial begin
        exp_t cur;
        bit   seen = 0;
        bit   pend_rdy = 0;
        int   held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                pend_rdy = 0;
            end else begin
                if (pend_rdy) begin
                    check("s_ready_after_release", s_ready, 1);
                    pend_rdy = 0;
                end
                if (r_valid) begin
                    if (!seen) begin
                        if (q.size() == 0) begin
                            check("unexpected_result", r_valid, 0);
                        end else begin
                            cur  = q.pop_front();
                            seen = 1;
                            held = 0;
                            check("latency", cyc - last_acc, CL + 1);
                            check("assign_vec", assign_vec, cur.vec);
                            check("r_sat", r_sat, cur.sat);
                            check("r_err", r_err, cur.err);
                            check("r_seq", r_seq, cur.seq);
                        end
                    end else begin
                        held++;
                        check("held_r_sat", r_sat, cur.sat);
                        check("held_r_err", r_err, cur.err);
                        check("held_r_seq", r_seq, cur.seq);
                        check("held_vec", assign_vec, cur.vec);
                        check("s_ready_in_resp", s_ready, 0);
                    end
                    if (hold_mode && held < 10) r_ready = 1'b0;
                    else if (hold_mode)         r_ready = 1'b1;
                    else                        r_ready = 1'($urandom_range(0, 1));
                    if (r_ready && seen) begin
                        seen = 0;
                        done++;
                        pend_rdy = 1;
                    end
                end else begin
                    r_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_vec", assign_vec, 0);
        check("rst_r_seq", r_seq, 0);
        check("rst_r_sat", r_sat, 0);
        check("rst_r_err", r_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);

        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h00AB;
        run_asg(3, 1'b1);
        wbuf[0] = 16'hFFFF; wbuf[1] = 16'hFFFF;
        run_asg(2, 1'b1);
        for (int i = 0; i < 5; i++) wbuf[i] = WW'($urandom);
        run_asg(5, 1'b1);
        for (int i = 0; i < 3; i++) wbuf[i] = WW'($urandom);
        run_asg(3, 1'b1);
        hold_mode = 1'b1;
        run_asg(3, 1'b1);
        hold_mode = 1'b0;

        // Reset in the middle of an assignment: nothing may come out.
        put_word(16'hDEAD, 1'b0);
        put_word(16'hBEEF, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_r_valid", r_valid, 0);
        check("midrst_vec", assign_vec, 0);
        rst  = 1'b0;
        mvec = '0;
        mseq = '0;
        run_asg(3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 8; i++) wbuf[i] = WW'($urandom);
            run_asg($urandom_range(1, 5), 1'($urandom));
        end

        // Zero-latency instance: result one cycle after the last word.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid0 = 1'b1;
            s_data0  = WW'(16'h0100 + i);
            s_last0  = (i == 2);
            t = 0;
            while (!s_ready0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid0 = 1'b0;
        check("lat0_not_yet", r_valid0, 0);
        @(negedge clk);
        check("lat0_valid", r_valid0, 1);
        check("lat0_sat", r_sat0, 1);
        check("lat0_err", r_err0, 0);
        check("lat0_seq", r_seq0, 0);
        check("lat0_vec", assign_vec0, 40'h0201010100);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
